// File: rtl/xbar_slave_arbiter_pkg.sv
// Shared crossbar definitions: command encoding, arbiter state type and the
// round-robin pick helper used by the slave-port arbiters.
package xbar_slave_arbiter_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Widest request vector the pick helper handles; callers zero-extend.
  localparam int MAX_MASTERS = 32;
  localparam int PICK_IDX_W  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [PICK_IDX_W-1:0] idx;
    logic                  found;
  } rr_pick_t;

  // First set bit of req[n-1:0] scanning upward from ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input int unsigned            n,
                                       input logic [PICK_IDX_W-1:0]  ptr);
    rr_pick_t    r;
    int unsigned pos;
    r.idx   = '0;
    r.found = 1'b0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= n) pos = pos - n;
      if (k < n && !r.found && req[pos[PICK_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = pos[PICK_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-and-find-first: index of the first requester at or
// after ptr, wrapping around N requesters.
module rr_priority_picker
  import xbar_slave_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  rr_pick_t pick;
  logic     unused_idx_hi;

  always_comb begin
    pick  = rr_pick(MAX_MASTERS'(req), N, PICK_IDX_W'(ptr));
    idx   = pick.idx[IDX_W-1:0];
    found = pick.found;
  end

  // Upper index bits are always zero for N below the helper's maximum.
  assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port crossbar arbiter: round-robin grant among masters, forwards
// the winner to the slave and routes ack/rdata back, with a no-ack watchdog.
module xbar_slave_arbiter
  import xbar_slave_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GW             = $clog2(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS-1:0]          m_cmd,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_cmd,
  output logic                          s_connect_approved,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [GW-1:0]                 grant_id
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t      state;
  logic [GW-1:0]   rr_ptr;
  logic [WD_W-1:0] wd_cnt;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;
  logic [GW-1:0]   next_ptr;
  logic            busy;
  logic            req_g;
  logic            wd_at_limit;
  logic            wd_expired;

  rr_priority_picker #(.N(N_MASTERS), .IDX_W(GW)) u_picker (
    .req   (m_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign busy        = (state == ST_BUSY);
  assign req_g       = m_req[grant_id];
  assign wd_at_limit = (wd_cnt == WD_LIMIT);
  // Ack and master abort both outrank the watchdog, so no err in those cycles.
  assign wd_expired  = busy && req_g && !s_ack && wd_at_limit;
  assign next_ptr    = (grant_id == GW'(N_MASTERS - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ack || !req_g || wd_at_limit) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_connect_approved = busy;
  assign s_req   = busy && req_g;
  assign s_addr  = busy ? m_addr[int'(grant_id)*ADDR_W +: ADDR_W] : '0;
  assign s_wdata = busy ? m_wdata[int'(grant_id)*DATA_W +: DATA_W] : '0;
  assign s_cmd   = (busy && m_cmd[grant_id] == CMD_WRITE) ? CMD_WRITE : CMD_READ;
  assign m_rdata = busy ? s_rdata : '0;

  always_comb begin
    m_ack = '0;
    m_err = '0;
    if (busy) begin
      m_ack[grant_id] = s_ack;
      m_err[grant_id] = wd_expired;
    end
  end

endmodule
